pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold levels, controller states and widths.
package pipe_ctrl_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned WD_W   = 32;
  localparam int unsigned LVL_W  = 3;
  localparam int unsigned FCNT_W = 2;

  // Boundary k (PC=1, if_id=2, id_ex=3, ex_mem=4) holds when level >= k.
  typedef enum logic [LVL_W-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3,
    HOLD_EX   = 3'd4,
    HOLD_MEM  = 3'd5
  } hold_level_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hold/redirect controller: hazard prioritisation, deferred redirects,
// post-redirect flush window, stall statistics and stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              load_use_i,
  input  logic              ex_busy_i,
  input  logic              mem_wait_i,
  output logic [LVL_W-1:0]  pipe_hold_en_o,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              stall_timeout_o
);

  ctrl_state_e       state_q, state_d;
  logic [FCNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [WD_W-1:0]   wd_q;
  logic [WD_W-1:0]   wd_inc;
  logic              timeout_q;
  logic              any_wait;
  hold_level_e       level;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;

  assign any_wait = mem_wait_i | ex_busy_i;
  assign wd_inc   = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);

  // Next-state, hold level and redirect strobe; waits dominate and defer redirects.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    level       = HOLD_NONE;
    jump_en     = 1'b0;
    jump_addr   = '0;

    if (any_wait) begin
      level       = mem_wait_i ? HOLD_MEM : HOLD_EX;
      state_d     = STALL;
      flush_cnt_d = '0;
      if (jump_req_i) begin
        pend_d      = 1'b1;
        pend_addr_d = jump_addr_i;
      end
    end else if (jump_req_i || pend_q) begin
      // A fresh request is newer than any latched one, so it wins.
      level     = HOLD_ID;
      jump_en   = 1'b1;
      jump_addr = jump_req_i ? jump_addr_i : pend_addr_q;
      pend_d    = 1'b0;
      if (FLUSH_CYCLES > 0) begin
        state_d     = FLUSH;
        flush_cnt_d = FCNT_W'(FLUSH_CYCLES);
      end else begin
        state_d = RUN;
      end
    end else begin
      if (load_use_i) begin
        level = HOLD_ID;
      end else if (state_q == FLUSH) begin
        level = HOLD_IF;
      end
      if (state_q == FLUSH) begin
        flush_cnt_d = flush_cnt_q - FCNT_W'(1);
        if (flush_cnt_q <= FCNT_W'(1)) begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stall_cnt_q <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      if ((level != HOLD_NONE) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      // Watchdog only tracks back-pressure from EX/MEM, not bubbles.
      if (level >= HOLD_EX) begin
        wd_q <= wd_inc;
        if (wd_inc >= WD_W'(STALL_TIMEOUT)) begin
          timeout_q <= 1'b1;
        end
      end else begin
        wd_q <= '0;
      end
    end
  end

  assign pipe_hold_en_o  = rst_n ? LVL_W'(level) : '0;
  assign jump_en_o       = rst_n & jump_en;
  assign jump_addr_o     = rst_n ? jump_addr : '0;
  assign stall_cnt_o     = stall_cnt_q;
  assign stall_timeout_o = timeout_q;

endmodule
